// File: rtl/key_schedule_ctrl_if.sv
// Key-load handshake, schedule status and round-key read port of key_schedule_ctrl.
// master = key source / round engine side, slave = the controller.
interface key_schedule_ctrl_if #(
  parameter int NK = 4
);
  logic [32*NK-1:0] key;
  logic             key_valid;
  logic             key_ready;
  logic             clear;
  logic             busy;
  logic             keys_ready;
  logic             rk_req;
  logic [3:0]       rk_round;
  logic             rk_valid;
  logic             rk_err;
  logic [127:0]     rk;

  modport master (
    output key, key_valid, clear, rk_req, rk_round,
    input  key_ready, busy, keys_ready, rk_valid, rk_err, rk
  );

  modport slave (
    input  key, key_valid, clear, rk_req, rk_round,
    output key_ready, busy, keys_ready, rk_valid, rk_err, rk
  );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128/192/256 key schedule: one word per cycle, full schedule stored, 1-cycle round-key reads.
// key_ready only in IDLE/READY; defining KEY_SCHED_ZEROIZE_EN makes clear wipe storage in a ZERO state.
module key_schedule_ctrl #(
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input logic                clk,
  input logic                rst_n,
  key_schedule_ctrl_if.slave bus
);
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] NK_W    = IW'(NK);
  localparam logic [IW-1:0] LAST_W  = IW'(NW - 1);
  localparam logic [2:0]    PH_LAST = 3'(NK - 1);
  localparam logic [3:0]    NR_W    = 4'(NR);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
`ifdef KEY_SCHED_ZEROIZE_EN
    ZERO,
`endif
    READY
  } state_t;

  // Byte b sits at bits [2047-8b -: 8], and 2047-8b == {~b, 3'b111}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     w_q [NW];
  logic [31:0]     w_d [NW];
  logic [IW-1:0]   idx_q, idx_d;
  logic [2:0]      phase_q, phase_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            busy_q, busy_d;
  logic            kready_q, kready_d;
  logic [127:0]    rk_q, rk_d;
  logic            rk_vld_q, rk_vld_d;
  logic            rk_err_q, rk_err_d;

  logic            accept, rd_ok, rd_hit;
  logic [IW-1:0]   rd_base;
  logic [31:0]     prev_w, sub_in, sub_out, new_w;

  assign bus.key_ready  = (state_q == IDLE) || (state_q == READY);
  assign bus.busy       = busy_q;
  assign bus.keys_ready = kready_q;
  assign bus.rk_valid   = rk_vld_q;
  assign bus.rk_err     = rk_err_q;
  assign bus.rk         = rk_q;

  assign accept  = bus.key_valid && bus.key_ready && !bus.clear;
  assign rd_ok   = (state_q == READY) && bus.rk_req && !bus.clear;
  assign rd_hit  = bus.rk_round <= NR_W;
  assign rd_base = rd_hit ? IW'({bus.rk_round, 2'b00}) : '0;

  // Single S-box bank: RotWord is applied in front of it only on Rcon words.
  assign prev_w  = w_q[idx_q - 1'b1];
  assign sub_in  = (phase_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
  assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};

  always_comb begin
    new_w = prev_w;
    if (phase_q == 3'd0) begin
      new_w = sub_out ^ {rcon_q, 24'h0};
    end else if (NK == 8 && phase_q == 3'd4) begin
      new_w = sub_out;
    end
    new_w = new_w ^ w_q[idx_q - NK_W];
  end

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    idx_d    = idx_q;
    phase_d  = phase_q;
    rcon_d   = rcon_q;
    rk_d     = rk_q;
    rk_vld_d = 1'b0;
    rk_err_d = 1'b0;

    // Reads sample the old schedule even when a rekey lands in the same cycle.
    if (rd_ok) begin
      if (rd_hit) begin
        rk_vld_d = 1'b1;
        rk_d     = {w_q[rd_base], w_q[rd_base + 1'b1], w_q[rd_base + 2'd2], w_q[rd_base + 2'd3]};
      end else begin
        rk_err_d = 1'b1;
      end
    end

    case (state_q)
      IDLE, READY: begin
        if (accept) begin
          for (int j = 0; j < NK; j++) begin
            w_d[IW'(j)] = bus.key[32*(NK-1-j) +: 32];
          end
          idx_d   = NK_W;
          phase_d = 3'd0;
          rcon_d  = 8'h01;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        w_d[idx_q] = new_w;
        idx_d      = idx_q + 1'b1;
        phase_d    = (phase_q == PH_LAST) ? 3'd0 : phase_q + 3'd1;
        if (phase_q == 3'd0) rcon_d = xtime(rcon_q);
        if (idx_q == LAST_W) state_d = READY;
      end
`ifdef KEY_SCHED_ZEROIZE_EN
      ZERO: begin
        w_d[idx_q] = '0;
        idx_d      = idx_q + 1'b1;
        if (idx_q == LAST_W) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef KEY_SCHED_ZEROIZE_EN
    if (bus.clear && state_q != ZERO) begin
      state_d  = ZERO;
      idx_d    = '0;
      rcon_d   = 8'h01;
      rk_d     = '0;
    end
    busy_d = (state_d == EXPAND) || (state_d == ZERO);
`else
    if (bus.clear) begin
      state_d = IDLE;
    end
    busy_d = (state_d == EXPAND);
`endif
    kready_d = (state_d == READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      w_q      <= '{default: '0};
      idx_q    <= '0;
      phase_q  <= '0;
      rcon_q   <= 8'h01;
      busy_q   <= 1'b0;
      kready_q <= 1'b0;
      rk_q     <= '0;
      rk_vld_q <= 1'b0;
      rk_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      idx_q    <= idx_d;
      phase_q  <= phase_d;
      rcon_q   <= rcon_d;
      busy_q   <= busy_d;
      kready_q <= kready_d;
      rk_q     <= rk_d;
      rk_vld_q <= rk_vld_d;
      rk_err_q <= rk_err_d;
    end
  end
endmodule
